// File: rtl/fir4_pkg.sv
// Shared constants and types for the 4-tap moving-sum FIR.
// Build option: FIR4_CSA_EN selects the carry-save adder tree.
package fir4_pkg;

  localparam int TAPS  = 4;
  localparam int W_DEF = 4;

  typedef logic [W_DEF-1:0] sample_t;
  typedef sample_t [TAPS-1:0] tap_arr_t;

  function automatic int sum_w(input int w);
    return w + 2;
  endfunction

endpackage

// File: rtl/fir4_rca_add.sv
// n-bit ripple-carry adder built from a chain of full adders.
module rca_add #(
  parameter int n = 4
) (
  input  logic [n-1:0] x,
  input  logic [n-1:0] y,
  input  logic         cin,
  output logic [n-1:0] sum,
  output logic         cout
);

  logic [n:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < n; i++) begin : g_fa
    assign sum[i]  = x[i] ^ y[i] ^ c[i];
    assign c[i+1]  = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign cout = c[n];

endmodule

// File: rtl/fir4_rca.sv
// 4-tap unsigned moving-sum FIR with a registered output.
// Build option: FIR4_CSA_EN selects a 4:2 carry-save tree.
module fir4_rca
  import fir4_pkg::*;
#(
  parameter int w = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [w-1:0]     a,
  output logic [w+1:0]     s
);

  localparam int SW = sum_w(w);

  logic [w-1:0]  ar, br, cr, dr;
  logic [SW-1:0] tot;

`ifdef FIR4_CSA_EN
  logic [w-1:0] s1, c1;
  logic [w:0]   s1e, c1s, de, s2;
  logic [w-1:0] c2;

  assign s1  = ar ^ br ^ cr;
  assign c1  = (ar & br) | (ar & cr) | (br & cr);
  assign s1e = {1'b0, s1};
  assign c1s = {c1, 1'b0};
  assign de  = {1'b0, dr};
  assign s2  = s1e ^ c1s ^ de;
  // carry out of bit w is always 0, so only w carry bits exist
  assign c2  = (s1e[w-1:0] & c1s[w-1:0])
             | (s1e[w-1:0] & de[w-1:0])
             | (c1s[w-1:0] & de[w-1:0]);

  rca_add #(.n(w+1)) u_fin (
    .x    (s2),
    .y    ({c2, 1'b0}),
    .cin  (1'b0),
    .sum  (tot[w:0]),
    .cout (tot[w+1])
  );
`else
  logic [w:0] ab, cd;

  rca_add #(.n(w)) u_ab (
    .x    (ar),
    .y    (br),
    .cin  (1'b0),
    .sum  (ab[w-1:0]),
    .cout (ab[w])
  );

  rca_add #(.n(w)) u_cd (
    .x    (cr),
    .y    (dr),
    .cin  (1'b0),
    .sum  (cd[w-1:0]),
    .cout (cd[w])
  );

  rca_add #(.n(w+1)) u_fin (
    .x    (ab),
    .y    (cd),
    .cin  (1'b0),
    .sum  (tot[w:0]),
    .cout (tot[w+1])
  );
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      ar <= '0;
      br <= '0;
      cr <= '0;
      dr <= '0;
      s  <= '0;
    end else begin
      ar <= a;
      br <= ar;
      cr <= br;
      dr <= cr;
      s  <= tot;
    end
  end

endmodule

// File: tb/tb_fir4_rca.sv
// Self-checking bench for fir4_rca against a shift-register golden model.
module tb_fir4_rca;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] a;
  logic [W+1:0] s;

  logic [W-1:0] g [4];
  logic [W+1:0] exp_q [$];

  int nvec  = 0;
  int nfail = 0;

  fir4_rca #(.w(W)) dut (
    .clk   (clk),
    .reset (reset),
    .a     (a),
    .s     (s)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [W+1:0] obs,
                     input logic [W+1:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s got %h exp %h", tag, obs, expv);
    end
  endtask

  // drive one sample, advance one edge, check scoreboard and optional constant
  task automatic step(input logic [W-1:0] av, input logic rv,
                      input string tag, input bit chk,
                      input logic [W+1:0] kv);
    logic [W+1:0] e;
    a     = av;
    reset = rv;
    if (rv) e = '0;
    else e = (W+2)'(g[0]) + (W+2)'(g[1]) + (W+2)'(g[2]) + (W+2)'(g[3]);
    exp_q.push_back(e);
    if (rv) begin
      for (int i = 0; i < 4; i++) g[i] = '0;
    end else begin
      g[3] = g[2];
      g[2] = g[1];
      g[1] = g[0];
      g[0] = av;
    end
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      nvec++;
      nfail++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      cmp(tag, s, exp_q.pop_front());
    end
    if (chk) cmp({tag, "_k"}, s, kv);
  endtask

  initial begin
    logic [W-1:0] fs;
    logic [W+1:0] ramp [5];
    fs = '1;
    ramp[0] = 1; ramp[1] = 3; ramp[2] = 6; ramp[3] = 10; ramp[4] = 14;
    for (int i = 0; i < 4; i++) g[i] = '0;
    reset = 1'b1;
    a     = '0;
    @(posedge clk);
    #1;

    step(4'h7, 1'b1, "rst0", 1'b1, 6'h00);
    step(4'h9, 1'b1, "rst1", 1'b1, 6'h00);
    step(4'h0, 1'b0, "rst_taps", 1'b1, 6'h00);

    // impulse
    step(4'h0, 1'b1, "imp_rst", 1'b1, 6'h00);
    step(fs,   1'b0, "imp0", 1'b1, 6'h00);
    for (int i = 0; i < 4; i++) step(4'h0, 1'b0, "imp_hi", 1'b1, 6'h0F);
    step(4'h0, 1'b0, "imp_lo", 1'b1, 6'h00);

    // full scale
    step(4'h0, 1'b1, "fs_rst", 1'b1, 6'h00);
    step(fs, 1'b0, "fs0", 1'b1, 6'h00);
    step(fs, 1'b0, "fs1", 1'b1, 6'h0F);
    step(fs, 1'b0, "fs2", 1'b1, 6'h1E);
    step(fs, 1'b0, "fs3", 1'b1, 6'h2D);
    step(fs, 1'b0, "fs4", 1'b1, 6'h3C);
    step(fs, 1'b0, "fs5", 1'b1, 6'h3C);

    // reset mid-stream, then refill
    step(fs, 1'b1, "mid_rst", 1'b1, 6'h00);
    step(fs, 1'b0, "refill0", 1'b1, 6'h00);
    step(fs, 1'b0, "refill1", 1'b1, 6'h0F);
    step(fs, 1'b0, "refill2", 1'b1, 6'h1E);

    // ramp
    step(4'h0, 1'b1, "ramp_rst", 1'b1, 6'h00);
    step(4'h1, 1'b0, "ramp0", 1'b1, 6'h00);
    for (int i = 0; i < 5; i++)
      step(4'(i + 2), 1'b0, "ramp", 1'b1, ramp[i]);

    // random, with occasional resets
    for (int i = 0; i < 1000; i++)
      step(4'($urandom_range(0, 15)), ($urandom_range(0, 63) == 0),
           "rand", 1'b0, 6'h00);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
